// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the pipe game controller and its helpers:
//   - game_state_t : top-level game FSM state
//   - KEY_W / KEY_SPACE : USB keycodes for flap/start and restart
//   - initial pipe positions, default gap row, random-gap base, LFSR seed
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } game_state_t;

  localparam logic [7:0]  KEY_W         = 8'h1A;
  localparam logic [7:0]  KEY_SPACE     = 8'h2C;

  localparam logic [10:0] PIPE0_INIT_X  = 11'd700;
  localparam logic [10:0] PIPE1_INIT_X  = 11'd1020;

  localparam logic [9:0]  GAP_DEFAULT   = 10'd160;
  localparam logic [9:0]  GAP_RAND_BASE = 10'd40;

  localparam logic [7:0]  LFSR_SEED     = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit maximal-length Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1.
// Shifts left once per enabled frame_clk edge; reset loads LFSR_SEED.
// Ports:
//   frame_clk : clock
//   Reset_n   : asynchronous active-low reset
//   en        : advance the register this edge
//   q         : current LFSR value
// -----------------------------------------------------------------------------
module lfsr8
  import game_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       en,
  output logic [7:0] q
);

  logic fb;

  // Taps 8,6,5,4 map to bit indices 7,5,4,3.
  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/pipe_game_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_game_ctrl
// Game controller for a two-pipe side scroller. Runs the IDLE/PLAY/DEAD FSM,
// scrolls and respawns the pipes, detects bird/pipe/ground collisions and
// keeps a two-digit BCD score.
//
// Build option:
//   PIPE_GAME_RANDOM_GAP_EN  defined   -> respawned gap row = 40 + LFSR value,
//                                         LFSR (lfsr8) advances each PLAY edge
//                            undefined -> respawned gap row fixed at 160,
//                                         no LFSR
//
// Ports:
//   frame_clk      : one rising edge per video frame
//   Reset_n        : asynchronous active-low reset
//   keycode[7:0]   : current USB keycode (8'h1A start, 8'h2C restart)
//   BallX/Y/S[9:0] : bird centre X, centre Y, half-size
//   Pipe0X/1X[10:0]: pipe right edges
//   Gap0Y/1Y[9:0]  : top row of each pipe's gap
//   Score[7:0]     : BCD score, [7:4] tens, [3:0] units
//   Playing / Dead : state decodes
// -----------------------------------------------------------------------------
module pipe_game_ctrl
  import game_pkg::*;
#(
  parameter int PIPE_W       = 60,
  parameter int GAP_H        = 160,
  parameter int PIPE_SPEED   = 2,
  parameter int PIPE_SPACING = 320,
  parameter int GROUND_Y     = 479
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [7:0]  keycode,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [9:0]  BallS,
  output logic [10:0] Pipe0X,
  output logic [10:0] Pipe1X,
  output logic [9:0]  Gap0Y,
  output logic [9:0]  Gap1Y,
  output logic [7:0]  Score,
  output logic        Playing,
  output logic        Dead
);

  localparam logic signed [10:0] PIPE_W_S   = 11'(PIPE_W);
  localparam logic signed [10:0] GAP_H_S    = 11'(GAP_H);
  localparam logic signed [10:0] GROUND_Y_S = 11'(GROUND_Y);
  localparam logic [10:0]        SPEED_X    = 11'(PIPE_SPEED);
  localparam logic [10:0]        SPACING_X  = 11'(PIPE_SPACING);

  game_state_t state, state_nxt;

  logic [10:0] pipe0_x, pipe1_x, pipe0_x_nxt, pipe1_x_nxt;
  logic [9:0]  gap0_y, gap1_y, gap0_y_nxt, gap1_y_nxt;
  logic [9:0]  gap_reload;
  logic [7:0]  score, score_nxt;
  logic        pass0, pass1, pass0_nxt, pass1_nxt;

  logic signed [10:0] ball_x_s, ball_y_s, ball_s_s;
  logic signed [10:0] ball_l, ball_r, ball_t, ball_b;
  logic signed [10:0] pipe0_s, pipe1_s, gap0_s, gap1_s;
  logic               hit, pass0_ok, pass1_ok;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens, units;
    tens  = v[7:4];
    units = v[3:0];
    if (units >= 4'd9) begin
      units = 4'd0;
      tens  = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  // Bird box against one pipe: overlapping the pipe column and outside the gap.
  function automatic logic pipe_hit(input logic signed [10:0] px,
                                    input logic signed [10:0] gy,
                                    input logic signed [10:0] l,
                                    input logic signed [10:0] r,
                                    input logic signed [10:0] t,
                                    input logic signed [10:0] b);
    logic x_ovl;
    x_ovl = (r > (px - PIPE_W_S)) && (l < px);
    return x_ovl && ((t < gy) || (b > (gy + GAP_H_S)));
  endfunction

`ifdef PIPE_GAME_RANDOM_GAP_EN
  logic [7:0] lfsr_q;

  lfsr8 u_lfsr (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .en        (state == ST_PLAY),
    .q         (lfsr_q)
  );

  assign gap_reload = GAP_RAND_BASE + {2'b00, lfsr_q};
`else
  assign gap_reload = GAP_DEFAULT;
`endif

  // All geometry is compared as 11-bit signed so left/top edges may go
  // negative when the bird is near the screen border.
  assign ball_x_s = signed'({1'b0, BallX});
  assign ball_y_s = signed'({1'b0, BallY});
  assign ball_s_s = signed'({1'b0, BallS});
  assign ball_l   = ball_x_s - ball_s_s;
  assign ball_r   = ball_x_s + ball_s_s;
  assign ball_t   = ball_y_s - ball_s_s;
  assign ball_b   = ball_y_s + ball_s_s;

  assign pipe0_s  = signed'(pipe0_x);
  assign pipe1_s  = signed'(pipe1_x);
  assign gap0_s   = signed'({1'b0, gap0_y});
  assign gap1_s   = signed'({1'b0, gap1_y});

  assign hit = pipe_hit(pipe0_s, gap0_s, ball_l, ball_r, ball_t, ball_b) ||
               pipe_hit(pipe1_s, gap1_s, ball_l, ball_r, ball_t, ball_b) ||
               (ball_b >= GROUND_Y_S);

  assign pass0_ok = !pass0 && (pipe0_s < ball_l);
  assign pass1_ok = !pass1 && (pipe1_s < ball_l);

  always_comb begin
    state_nxt   = state;
    pipe0_x_nxt = pipe0_x;
    pipe1_x_nxt = pipe1_x;
    gap0_y_nxt  = gap0_y;
    gap1_y_nxt  = gap1_y;
    score_nxt   = score;
    pass0_nxt   = pass0;
    pass1_nxt   = pass1;

    case (state)
      ST_IDLE: begin
        if (keycode == KEY_W) begin
          state_nxt = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // A hit freezes everything, including any pass due on this edge.
        if (hit) begin
          state_nxt = ST_DEAD;
        end else begin
          // Only one point per edge; pipe 1 picks its pass up next edge.
          if (pass0_ok) begin
            pass0_nxt = 1'b1;
            score_nxt = bcd_inc(score);
          end else if (pass1_ok) begin
            pass1_nxt = 1'b1;
            score_nxt = bcd_inc(score);
          end

          // Respawn is placed relative to the other pipe's pre-edge X so the
          // pair keeps its spacing after the other pipe moves this edge.
          if (pipe0_x < SPEED_X) begin
            pipe0_x_nxt = pipe1_x - SPEED_X + SPACING_X;
            gap0_y_nxt  = gap_reload;
            pass0_nxt   = 1'b0;
          end else begin
            pipe0_x_nxt = pipe0_x - SPEED_X;
          end

          if (pipe1_x < SPEED_X) begin
            pipe1_x_nxt = pipe0_x - SPEED_X + SPACING_X;
            gap1_y_nxt  = gap_reload;
            pass1_nxt   = 1'b0;
          end else begin
            pipe1_x_nxt = pipe1_x - SPEED_X;
          end
        end
      end

      ST_DEAD: begin
        if (keycode == KEY_SPACE) begin
          state_nxt   = ST_IDLE;
          pipe0_x_nxt = PIPE0_INIT_X;
          pipe1_x_nxt = PIPE1_INIT_X;
          gap0_y_nxt  = GAP_DEFAULT;
          gap1_y_nxt  = GAP_DEFAULT;
          score_nxt   = 8'h00;
          pass0_nxt   = 1'b0;
          pass1_nxt   = 1'b0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      pipe0_x <= PIPE0_INIT_X;
      pipe1_x <= PIPE1_INIT_X;
      gap0_y  <= GAP_DEFAULT;
      gap1_y  <= GAP_DEFAULT;
      score   <= 8'h00;
      pass0   <= 1'b0;
      pass1   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pipe0_x <= pipe0_x_nxt;
      pipe1_x <= pipe1_x_nxt;
      gap0_y  <= gap0_y_nxt;
      gap1_y  <= gap1_y_nxt;
      score   <= score_nxt;
      pass0   <= pass0_nxt;
      pass1   <= pass1_nxt;
    end
  end

  assign Pipe0X  = pipe0_x;
  assign Pipe1X  = pipe1_x;
  assign Gap0Y   = gap0_y;
  assign Gap1Y   = gap1_y;
  assign Score   = score;
  assign Playing = (state == ST_PLAY);
  assign Dead    = (state == ST_DEAD);

endmodule
